seg7_readback: RTL and testbench

Reconstructs BCD digits from a multiplexed seven-segment bus: the inverse of the team's BCD-to-segment encoder. Samples segment pattern plus one-hot digit select, requires each pattern to be stable before accepting it, decodes it to BCD, and assembles a full multi-digit frame. Hands the frame out over a valid/ready handshake. Used for display read-back and self-check in the number guessing game.

---
 rtl/seg7_readback.sv | 135 +++++++++++++
 tb/tb_seg7_readback.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback.sv
// Seven-segment bus read-back: debounces each multiplexed digit, decodes it to BCD and
// assembles full frames behind a valid/ready output. Define SEG_ACTIVE_LOW_EN for common-anode buses.
module seg7_readback #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            sevenseg,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  frame_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  pattern_err
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [6:0] seg_in;
`ifdef SEG_ACTIVE_LOW_EN
    assign seg_in = ~sevenseg;
`else
    assign seg_in = sevenseg;
`endif

    logic [6+DIGITS:0] sample_reg;
    logic [CW-1:0]     cnt_reg;
    logic              sel_onehot;
    logic              same_sample;
    logic              capture;

    assign sel_onehot  = $onehot(digit_sel);
    assign same_sample = ({seg_in, digit_sel} == sample_reg);
    // Fires exactly once per stable window: the counter saturates at CNT_MAX afterwards.
    assign capture     = sel_onehot && same_sample && (cnt_reg == CNT_CAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            sample_reg <= {seg_in, digit_sel};
            if (!sel_onehot || !same_sample)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    logic [3:0] dec_val;
    logic       dec_blank;
    logic       dec_inv;

    always_comb begin
        dec_val   = 4'hE;
        dec_blank = 1'b0;
        dec_inv   = 1'b0;
        case (seg_in)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            7'b0000000: begin
                dec_val   = 4'hF;
                dec_blank = 1'b1;
            end
            default: dec_inv = 1'b1;
        endcase
    end

    logic [DIGITS-1:0][3:0] slot_reg, slot_next;
    logic [DIGITS-1:0]      blank_reg, blank_next;
    logic [DIGITS-1:0]      mask_reg, mask_next;
    logic                   err_reg, err_next;
    logic [0:0]             state_reg;
    logic                   frame_done;
    logic                   load;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_slot
            assign slot_next[gi]  = (capture && digit_sel[gi]) ? dec_val   : slot_reg[gi];
            assign blank_next[gi] = (capture && digit_sel[gi]) ? dec_blank : blank_reg[gi];
        end
    endgenerate

    assign frame_done = &mask_reg;
    assign load       = frame_done && ((state_reg == ST_EMPTY) || out_ready);
    // A capture on the load edge already belongs to the next frame.
    assign mask_next  = (load ? '0 : mask_reg) | (capture ? digit_sel : '0);
    assign err_next   = (load ? 1'b0 : err_reg) | (capture && dec_inv);
    assign out_valid  = (state_reg == ST_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg    <= '0;
            blank_reg   <= '0;
            mask_reg    <= '0;
            err_reg     <= 1'b0;
            state_reg   <= ST_EMPTY;
            bcd_out     <= '0;
            blank_mask  <= '0;
            frame_err   <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            slot_reg    <= slot_next;
            blank_reg   <= blank_next;
            mask_reg    <= mask_next;
            err_reg     <= err_next;
            pattern_err <= capture && dec_inv;
            if (load) begin
                bcd_out    <= slot_reg;
                blank_mask <= blank_reg;
                frame_err  <= err_reg;
                state_reg  <= ST_FULL;
            end else if ((state_reg == ST_FULL) && out_ready) begin
                state_reg  <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_seg7_readback.sv
// Randomised and directed bench for seg7_readback against a frame-level reference model.
module tb_seg7_readback;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  sevenseg = '0;
    logic [3:0]  digit_sel = '0;
    logic        out_ready = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;
    logic        frame_err;
    logic        out_valid;
    logic        pattern_err;

    int checks = 0;
    int failures = 0;
    int perr_seen = 0;

    logic [6:0] seg_tbl [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [6:0] cur_pat = '0;

    // reference model state
    logic [10:0] m_last;
    int          m_run;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_blank, m_mask, m_bmask;
    logic        m_err, m_ov, m_ferr, m_perr;
    logic [15:0] m_bcd;

    always #5 clk = ~clk;

    seg7_readback #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .sevenseg(sevenseg), .digit_sel(digit_sel),
        .bcd_out(bcd_out), .blank_mask(blank_mask), .frame_err(frame_err),
        .out_valid(out_valid), .out_ready(out_ready), .pattern_err(pattern_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last = '0; m_run = 0; m_blank = '0; m_mask = '0; m_bmask = '0;
        m_err = 1'b0; m_ov = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_bcd = '0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
    endtask

    task automatic mdecode(input logic [6:0] p, output logic [3:0] v, output logic bl, output logic inv);
        v = 4'hE; bl = 1'b0; inv = 1'b1;
        if (p == 7'b0) begin
            v = 4'hF; bl = 1'b1; inv = 1'b0;
        end else begin
            for (int i = 0; i < 10; i++)
                if (seg_tbl[i] == p) begin
                    v = 4'(i); inv = 1'b0;
                end
        end
    endtask

    // One clock edge of the reference: run-length debounce, then frame hand-off.
    task automatic model_step();
        logic [10:0] s;
        logic onehot, cap, bl, inv, load;
        logic [3:0] v;
        s = {cur_pat, digit_sel};
        onehot = ($countones(digit_sel) == 1);
        if (!onehot) m_run = 0;
        else if (s == m_last) m_run++;
        else m_run = 1;
        m_last = s;
        cap = onehot && (m_run == STABLE);
        mdecode(cur_pat, v, bl, inv);
        load = (m_mask == 4'hF) && (!m_ov || out_ready);
        if (load) begin
            for (int i = 0; i < 4; i++) m_bcd[4*i +: 4] = m_slot[i];
            m_bmask = m_blank; m_ferr = m_err; m_ov = 1'b1;
            m_mask = '0; m_err = 1'b0;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        m_perr = cap && inv;
        if (cap) begin
            for (int i = 0; i < 4; i++)
                if (digit_sel[i]) begin
                    m_slot[i] = v; m_blank[i] = bl; m_mask[i] = 1'b1;
                end
            if (inv) m_err = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (pattern_err) perr_seen++;
        check_eq("valid", 32'(out_valid), 32'(m_ov));
        check_eq("perr", 32'(pattern_err), 32'(m_perr));
        check_eq("frame", 32'({frame_err, blank_mask, bcd_out}), 32'({m_ferr, m_bmask, m_bcd}));
    endtask

    task automatic set_inputs(input logic [6:0] pat, input logic [3:0] sel);
        cur_pat = pat;
`ifdef SEG_ACTIVE_LOW_EN
        sevenseg = ~pat;
`else
        sevenseg = pat;
`endif
        digit_sel = sel;
    endtask

    task automatic drive(input logic [6:0] pat, input logic [3:0] sel, input int n);
        set_inputs(pat, sel);
        repeat (n) tick();
    endtask

    task automatic scan4(input int d0, input int d1, input int d2, input int d3);
        drive(seg_tbl[d0], 4'b0001, 8);
        drive(seg_tbl[d1], 4'b0010, 8);
        drive(seg_tbl[d2], 4'b0100, 8);
        drive(seg_tbl[d3], 4'b1000, 8);
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_outs"}, 32'({pattern_err, frame_err, blank_mask, bcd_out}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        int n;
        logic [6:0] pat;
        logic [3:0] sel;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_outs", 32'({pattern_err, frame_err, blank_mask, bcd_out}), 32'd0);
        rst = 1'b0;

        // basic scan
        scan4(1, 2, 3, 4);
        drive(7'b0, 4'b0000, 3);
        check_eq("scan_valid", 32'(out_valid), 32'd1);
        check_eq("scan_bcd", 32'(bcd_out), 32'h4321);
        check_eq("scan_flags", 32'({frame_err, blank_mask}), 32'd0);
        pulse_ready();
        check_eq("scan_accept", 32'(out_valid), 32'd0);

        // glitch: 3-cycle hold on slot 1 must not capture
        drive(seg_tbl[1], 4'b0001, 8);
        drive(seg_tbl[2], 4'b0010, 3);
        drive(seg_tbl[3], 4'b0100, 8);
        drive(seg_tbl[4], 4'b1000, 8);
        drive(7'b0, 4'b0000, 3);
        check_eq("glitch_novalid", 32'(out_valid), 32'd0);
        check_eq("glitch_noperr", 32'(perr_seen), 32'd0);
        drive(seg_tbl[2], 4'b0010, 4);
        drive(7'b0, 4'b0000, 2);
        check_eq("glitch_valid", 32'(out_valid), 32'd1);
        check_eq("glitch_bcd", 32'(bcd_out), 32'h4321);
        pulse_ready();

        // invalid and blank patterns
        p0 = perr_seen;
        drive(seg_tbl[1], 4'b0001, 8);
        drive(seg_tbl[2], 4'b0010, 8);
        drive(7'b1000000, 4'b0100, 8);
        drive(7'b0000000, 4'b1000, 8);
        drive(7'b0, 4'b0000, 3);
        check_eq("inv_perr_count", 32'(perr_seen - p0), 32'd1);
        check_eq("inv_bcd", 32'(bcd_out), 32'hFE21);
        check_eq("inv_blank", 32'(blank_mask), 32'b1000);
        check_eq("inv_ferr", 32'(frame_err), 32'd1);
        pulse_ready();

        // backpressure across two complete scans
        scan4(1, 2, 3, 4);
        scan4(5, 6, 7, 8);
        drive(7'b0, 4'b0000, 3);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_bcd", 32'(bcd_out), 32'h4321);
        pulse_ready();
        check_eq("bp_next_valid", 32'(out_valid), 32'd1);
        check_eq("bp_next_bcd", 32'(bcd_out), 32'h8765);
        pulse_ready();
        check_eq("bp_drain", 32'(out_valid), 32'd0);

        // zero and multi-hot select
        p0 = perr_seen;
        drive(7'b1000000, 4'b0000, 10);
        drive(7'b1000000, 4'b0110, 10);
        check_eq("badsel_perr", 32'(perr_seen - p0), 32'd0);
        check_eq("badsel_valid", 32'(out_valid), 32'd0);

        // reset mid-collection
        drive(seg_tbl[9], 4'b0001, 8);
        drive(seg_tbl[8], 4'b0010, 8);
        do_reset("midrst");
        scan4(9, 8, 7, 6);
        drive(7'b0, 4'b0000, 3);
        check_eq("postrst_valid", 32'(out_valid), 32'd1);
        check_eq("postrst_bcd", 32'(bcd_out), 32'h6789);
        pulse_ready();

        // randomised segments with random backpressure
        for (int k = 0; k < 300; k++) begin
            p0 = int'($urandom_range(0, 11));
            if (p0 < 10) pat = seg_tbl[p0];
            else if (p0 == 10) pat = 7'b0;
            else pat = 7'($urandom);
            if ($urandom_range(0, 9) < 8) sel = 4'b0001 << $urandom_range(0, 3);
            else sel = 4'($urandom);
            n = int'($urandom_range(1, 8));
            set_inputs(pat, sel);
            for (int c = 0; c < n; c++) begin
                out_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
        end
        out_ready = 1'b0;
        scan4(1, 2, 3, 4);
        scan4(5, 6, 7, 8);
        do_reset("endrst");
        drive(7'b0, 4'b0000, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
